// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus: single-outstanding req/gnt/rvalid handshake.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Keeps one fetch outstanding, buffers a word under decode stall, drops words made stale by redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_pc_src_e,
    input  logic [31:0] i_pc_target_e,
    if_stage_if.master  m_imem,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pcf;
    logic [31:0] w_pcf_nxt;
    logic [31:0] w_pcf_plus4;
    logic [31:0] w_target_aligned;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;

    logic        w_req;
    logic        w_rsp;
    logic [31:0] w_rsp_data;
    logic        w_deliver;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    // Gated by rst_n so no request escapes while reset is held.
    assign w_req            = rst_n && (r_state == ST_REQ) && !i_stall_f && !i_pc_src_e;
    assign w_pcf_plus4      = r_pcf + 32'd4;
    assign w_target_aligned = i_pc_target_e & ~32'd3;

    assign m_imem.req  = w_req;
    assign m_imem.addr = r_pcf;

    always_comb begin
        w_state_nxt = r_state;
        w_pcf_nxt   = r_pcf;
        w_drop_nxt  = r_drop;
        w_hold_nxt  = r_hold;
        w_rsp       = 1'b0;
        w_rsp_data  = m_imem.rdata;
        w_deliver   = 1'b0;

        unique case (r_state)
            ST_REQ: begin
                if (w_req && m_imem.gnt) begin
                    if (m_imem.rvalid) begin
                        w_rsp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_imem.rvalid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_rsp = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                w_rsp_data = r_hold;
                if (!i_stall_d) begin
                    w_rsp = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        // A word that decode cannot take this cycle is parked rather than refetched.
        if (w_rsp) begin
            if (i_stall_d || i_flush_d) begin
                w_hold_nxt  = w_rsp_data;
                w_state_nxt = ST_HOLD;
            end else begin
                w_deliver   = 1'b1;
                w_pcf_nxt   = w_pcf_plus4;
                w_state_nxt = ST_REQ;
            end
        end

        if (i_pc_src_e) begin
            w_pcf_nxt = w_target_aligned;
            w_deliver = 1'b0;
            // Still waiting on the old word: remember to swallow it when it finally shows up.
            if ((r_state == ST_WAIT) && !m_imem.rvalid) begin
                w_drop_nxt  = 1'b1;
                w_state_nxt = ST_WAIT;
            end else begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
            r_pcf   <= RESET_PC;
            r_drop  <= 1'b0;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
            r_drop  <= w_drop_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (i_flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (i_stall_d) begin
            r_instr_d    <= r_instr_d;
            r_pc_d       <= r_pc_d;
            r_pc_plus4_d <= r_pc_plus4_d;
            r_valid_d    <= r_valid_d;
        end else if (w_deliver) begin
            r_instr_d    <= w_rsp_data;
            r_pc_d       <= r_pcf;
            r_pc_plus4_d <= w_pcf_plus4;
            r_valid_d    <= 1'b1;
        end else begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end
    end

    assign o_instr_d    = r_instr_d;
    assign o_pc_d       = r_pc_d;
    assign o_pc_plus4_d = r_pc_plus4_d;
    assign o_valid_d    = r_valid_d;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/flush/redirect traffic,
// checked each cycle against a program-order model of the fetched instruction stream.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    if_stage_if imem_bus ();

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_stall_f    (stall_f),
        .i_stall_d    (stall_d),
        .i_flush_d    (flush_d),
        .i_pc_src_e   (pc_src_e),
        .i_pc_target_e(pc_target_e),
        .m_imem       (imem_bus),
        .o_instr_d    (instr_d),
        .o_pc_d       (pc_d),
        .o_pc_plus4_d (pc_plus4_d),
        .o_valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Memory: grant when free, answer after mem_lat cycles (0 = same cycle), optional stray rvalid.
    int          mem_lat = 0;
    logic        gnt_ok = 1'b1;
    logic        spur = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = 32'd0;

    always_comb begin
        imem_bus.gnt    = imem_bus.req && gnt_ok && !mem_busy;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = 32'hDEAD_BEEF;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_bus.rvalid = 1'b1;
                imem_bus.rdata  = word_of(mem_addr_q);
            end
        end else if (imem_bus.gnt && mem_lat == 0) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = word_of(imem_bus.addr);
        end else if (spur && !imem_bus.gnt) begin
            imem_bus.rvalid = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else mem_cnt <= mem_cnt - 1;
        end else if (imem_bus.gnt && mem_lat != 0) begin
            mem_busy   <= 1'b1;
            mem_cnt    <= mem_lat - 1;
            mem_addr_q <= imem_bus.addr;
        end
    end

    // Program-order model: the fetch PC is always the PC of the next instruction decode will see.
    logic [31:0] exp_pc = RESET_PC;
    logic        p_rst = 1'b1;
    logic        p_sd = 1'b0;
    logic        p_fd = 1'b0;
    logic        p_pc = 1'b0;
    logic [31:0] p_tgt = 32'd0;
    logic [31:0] o_instr = 32'd0;
    logic [31:0] o_pc = 32'd0;
    logic [31:0] o_p4 = 32'd0;
    logic        o_v = 1'b0;
    int          n_deliv = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_valid", valid_d, 1'b0);
            chk("rst_instr", instr_d, NOP);
            chk("rst_pcd", pc_d, 32'd0);
            chk1("rst_req", imem_bus.req, 1'b0);
            exp_pc = RESET_PC;
            p_rst  = 1'b1;
        end else begin
            if (p_rst || p_fd || (p_pc && !p_sd)) begin
                chk1("bubble_valid", valid_d, 1'b0);
            end else if (p_sd) begin
                chk("hold_instr", instr_d, o_instr);
                chk("hold_pcd", pc_d, o_pc);
                chk("hold_p4", pc_plus4_d, o_p4);
                chk1("hold_valid", valid_d, o_v);
            end else if (valid_d) begin
                chk("seq_pcd", pc_d, exp_pc);
                chk("seq_instr", instr_d, word_of(exp_pc));
                chk("seq_p4", pc_plus4_d, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (!valid_d) begin
                chk("nop_instr", instr_d, NOP);
                chk("nop_pcd", pc_d, 32'd0);
                chk("nop_p4", pc_plus4_d, 32'd0);
            end
            if (!p_rst && p_pc) exp_pc = p_tgt & 32'hFFFF_FFFC;
            if (imem_bus.req) chk("req_addr", imem_bus.addr, exp_pc);
            if (stall_f || pc_src_e) chk1("req_suppressed", imem_bus.req, 1'b0);
            p_rst = 1'b0;
        end
        p_sd    = stall_d;
        p_fd    = flush_d;
        p_pc    = pc_src_e;
        p_tgt   = pc_target_e;
        o_instr = instr_d;
        o_pc    = pc_d;
        o_p4    = pc_plus4_d;
        o_v     = valid_d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (valid_d) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: no ValidD within %0d cycles, required one", name, max);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [31:0] pexp;
        int          nreq;
        int          d0;
        int          r;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk1("t0_valid", valid_d, 1'b0);
        chk("t0_instr", instr_d, 32'h0000_0013);
        chk1("t0_req", imem_bus.req, 1'b0);

        // Zero-wait memory: one instruction per cycle from RESET_PC
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("t1_req", imem_bus.req, 1'b1);
        chk("t1_addr", imem_bus.addr, 32'h0000_0000);
        pexp = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("t1_valid", valid_d, 1'b1);
            chk("t1_pcd", pc_d, pexp);
            chk("t1_p4", pc_plus4_d, pexp + 32'd4);
            pexp = pexp + 32'd4;
        end

        // 2-cycle latency: one instruction per three cycles
        step();
        mem_lat = 2;
        wait_valid("t2_first", 10);
        base = pc_d;
        nreq = 0;
        if (imem_bus.req) nreq++;
        @(negedge clk);
        chk1("t2_gap1", valid_d, 1'b0);
        if (imem_bus.req) nreq++;
        @(negedge clk);
        chk1("t2_gap2", valid_d, 1'b0);
        if (imem_bus.req) nreq++;
        @(negedge clk);
        chk1("t2_valid", valid_d, 1'b1);
        chk("t2_pcd", pc_d, base + 32'd4);
        chk("t2_nreq", 32'(nreq), 32'd1);

        // Decode stall while the response arrives: held, buffered, delivered once
        step();
        mem_lat = 0;
        wait_valid("t3_sync", 10);
        step();
        stall_d = 1'b1;
        @(negedge clk);
        base = pc_d;
        chk1("t3_valid", valid_d, 1'b1);
        nreq = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("t3_held_pcd", pc_d, base);
            if (imem_bus.req) nreq++;
        end
        step();
        stall_d = 1'b0;
        @(negedge clk);
        chk("t3_held_last", pc_d, base);
        if (imem_bus.req) nreq++;
        chk("t3_no_refetch", 32'(nreq), 32'd0);
        @(negedge clk);
        chk("t3_release_pcd", pc_d, base + 32'd4);
        chk("t3_next_addr", imem_bus.addr, base + 32'd8);

        // Redirect while waiting on a slow response
        step();
        mem_lat = 3;
        wait_valid("t4_sync", 10);
        step();
        pc_src_e    = 1'b1;
        pc_target_e = 32'h0000_0100;
        @(negedge clk);
        chk1("t4_req_withdrawn", imem_bus.req, 1'b0);
        step();
        pc_src_e = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10 && nreq == 0; i++) begin
            @(negedge clk);
            if (imem_bus.req) nreq = 1;
        end
        chk("t4_req_seen", 32'(nreq), 32'd1);
        chk("t4_addr", imem_bus.addr, 32'h0000_0100);
        wait_valid("t4_valid", 10);
        chk("t4_pcd", pc_d, 32'h0000_0100);

        // Flush together with stall, then PC wrap at the top of memory
        step();
        mem_lat = 0;
        wait_valid("t5_sync", 10);
        step();
        stall_d = 1'b1;
        flush_d = 1'b1;
        stall_f = 1'b1;
        step();
        stall_d = 1'b0;
        flush_d = 1'b0;
        stall_f = 1'b0;
        @(negedge clk);
        chk1("t5_flush_valid", valid_d, 1'b0);
        chk("t5_flush_instr", instr_d, 32'h0000_0013);
        step();
        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFFF;
        step();
        pc_src_e = 1'b0;
        @(negedge clk);
        chk("t5_wrap_addr", imem_bus.addr, 32'hFFFF_FFFC);
        wait_valid("t5_wrap_valid", 10);
        chk("t5_wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("t5_wrap_p4", pc_plus4_d, 32'h0000_0000);
        @(negedge clk);
        chk("t5_after_wrap", pc_d, 32'h0000_0000);

        // Reset pulse while a slow fetch is in flight
        step();
        mem_lat = 4;
        wait_valid("t6_sync", 10);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk1("t6_valid", valid_d, 1'b0);
        chk("t6_instr", instr_d, 32'h0000_0013);
        chk("t6_pcd", pc_d, 32'h0000_0000);
        chk1("t6_req", imem_bus.req, 1'b0);
        step();
        rst_n = 1'b1;
        wait_valid("t6_restart", 20);
        chk("t6_restart_pcd", pc_d, 32'h0000_0000);
        chk("t6_restart_instr", instr_d, word_of(32'h0000_0000));

        // Randomized traffic against the running model
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i % 64 == 0) mem_lat = int'($urandom_range(0, 3));
            r           = int'($urandom_range(0, 99));
            stall_d     = (r < 15);
            stall_f     = (r < 15) || (r >= 95);
            flush_d     = ($urandom_range(0, 99) < 6);
            pc_src_e    = ($urandom_range(0, 99) < 5);
            pc_target_e = $urandom;
            gnt_ok      = ($urandom_range(0, 99) < 80);
            spur        = ($urandom_range(0, 99) < 10);
        end
        step();
        stall_d  = 1'b0;
        stall_f  = 1'b0;
        flush_d  = 1'b0;
        pc_src_e = 1'b0;
        gnt_ok   = 1'b1;
        spur     = 1'b0;
        repeat (10) step();
        chk1("rand_progress", (n_deliv - d0) > 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
